// File: rtl/spec_free_list_pkg.sv
// Shared sizing, types and the 4-lane prefix-sum helper for the speculative
// physical-register free list.
package spec_free_list_pkg;

  localparam int SIZE_PHYSICAL_TABLE = 96;
  localparam int SIZE_PHYSICAL_LOG   = 7;
  localparam int SIZE_RMT            = 32;
  // Must stay a power of two: pointers wrap by plain truncating addition.
  localparam int FL_DEPTH            = SIZE_PHYSICAL_TABLE - SIZE_RMT;
  localparam int FL_DEPTH_LOG        = 6;
  localparam int NUM_LANES           = 4;

  typedef logic [SIZE_PHYSICAL_LOG-1:0] phys_reg_t;
  typedef logic [FL_DEPTH_LOG-1:0]      fl_ptr_t;
  typedef logic [FL_DEPTH_LOG:0]        fl_cnt_t;
  typedef logic [2:0]                   lane_cnt_t;

  // Per-lane compacted offset (number of valid lanes below it) plus total.
  typedef struct packed {
    logic [NUM_LANES-1:0][1:0] offset;
    lane_cnt_t                 count;
  } prefix_sum_t;

  function automatic prefix_sum_t prefix_sum4(input logic [NUM_LANES-1:0] valid);
    prefix_sum_t r;
    lane_cnt_t   run;
    run = '0;
    r   = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      r.offset[l] = run[1:0];
      run         = run + {2'b00, valid[l]};
    end
    r.count = run;
    return r;
  endfunction

endpackage

// File: rtl/spec_free_list_if.sv
// Rename / map-table facing bundle of the free list. The master side is the
// pipeline (drives requests and releases); the slave side is the free list.
// There is no valid/ready handshake: reqCount_i is only honoured while
// freeListEmpty_o is low and recoverFlag_i is low, and released lanes are
// always accepted in the cycle they are presented.
interface spec_free_list_if;
  import spec_free_list_pkg::*;

  logic [2:0] reqCount_i;
  logic       releasedValid0_i;
  logic       releasedValid1_i;
  logic       releasedValid2_i;
  logic       releasedValid3_i;
  phys_reg_t  releasedPhyMap0_i;
  phys_reg_t  releasedPhyMap1_i;
  phys_reg_t  releasedPhyMap2_i;
  phys_reg_t  releasedPhyMap3_i;
  logic       recoverFlag_i;

  phys_reg_t  freeReg0_o;
  phys_reg_t  freeReg1_o;
  phys_reg_t  freeReg2_o;
  phys_reg_t  freeReg3_o;
  logic       freeListEmpty_o;
  fl_cnt_t    freeCount_o;

  // Pointer visibility for checkers.
  fl_ptr_t    dbg_head_ptr;
  fl_ptr_t    dbg_commit_head_ptr;
  fl_ptr_t    dbg_tail_ptr;

  modport master (
    output reqCount_i, releasedValid0_i, releasedValid1_i, releasedValid2_i,
           releasedValid3_i, releasedPhyMap0_i, releasedPhyMap1_i,
           releasedPhyMap2_i, releasedPhyMap3_i, recoverFlag_i,
    input  freeReg0_o, freeReg1_o, freeReg2_o, freeReg3_o, freeListEmpty_o,
           freeCount_o, dbg_head_ptr, dbg_commit_head_ptr, dbg_tail_ptr
  );

  modport slave (
    input  reqCount_i, releasedValid0_i, releasedValid1_i, releasedValid2_i,
           releasedValid3_i, releasedPhyMap0_i, releasedPhyMap1_i,
           releasedPhyMap2_i, releasedPhyMap3_i, recoverFlag_i,
    output freeReg0_o, freeReg1_o, freeReg2_o, freeReg3_o, freeListEmpty_o,
           freeCount_o, dbg_head_ptr, dbg_commit_head_ptr, dbg_tail_ptr
  );

endinterface

// File: rtl/spec_free_list_release_compact.sv
// Compacts the four released-register lanes: each valid lane gets the write
// offset equal to the number of valid lanes below it, so valid lanes land at
// consecutive tail slots in lane order.
module fl_release_compact
  import spec_free_list_pkg::*;
(
  input  logic [NUM_LANES-1:0]      valid_i,
  input  phys_reg_t                 idx_i     [NUM_LANES],
  output logic [NUM_LANES-1:0][1:0] offset_o,
  output phys_reg_t                 wr_data_o [NUM_LANES],
  output lane_cnt_t                 rel_cnt_o
);

  prefix_sum_t ps;

  // Prefix sum over the lane valids; invalid lanes present zero data.
  always_comb begin
    ps        = prefix_sum4(valid_i);
    offset_o  = ps.offset;
    rel_cnt_o = ps.count;
    for (int l = 0; l < NUM_LANES; l++) begin
      wr_data_o[l] = valid_i[l] ? idx_i[l] : '0;
    end
  end

endmodule

// File: rtl/spec_free_list.sv
// Speculative physical-register free list. Rename pops up to 4 entries from
// the head, commit pushes up to 4 freed registers at the tail, and recovery
// snaps the speculative head back to the committed head.
module spec_free_list
  import spec_free_list_pkg::*;
(
  input logic              clk,
  input logic              reset,
  spec_free_list_if.slave  fl_if
);

  phys_reg_t fl_q [FL_DEPTH];
  phys_reg_t fl_d [FL_DEPTH];
  fl_ptr_t   head_ptr_q, head_ptr_d;
  fl_ptr_t   commit_head_ptr_q, commit_head_ptr_d;
  fl_ptr_t   tail_ptr_q, tail_ptr_d;
  fl_cnt_t   free_cnt_q, free_cnt_d;

  logic [NUM_LANES-1:0]      rel_valid;
  phys_reg_t                 rel_idx  [NUM_LANES];
  logic [NUM_LANES-1:0][1:0] rel_offset;
  phys_reg_t                 rel_data [NUM_LANES];
  lane_cnt_t                 rel_cnt;

  lane_cnt_t                 req_cnt;
  lane_cnt_t                 alloc_cnt;
  logic                      empty;
  fl_ptr_t                   wr_ptr;
  logic [FL_DEPTH_LOG+1:0]   cnt_sum;

  assign rel_valid = {fl_if.releasedValid3_i, fl_if.releasedValid2_i,
                      fl_if.releasedValid1_i, fl_if.releasedValid0_i};
  assign rel_idx[0] = fl_if.releasedPhyMap0_i;
  assign rel_idx[1] = fl_if.releasedPhyMap1_i;
  assign rel_idx[2] = fl_if.releasedPhyMap2_i;
  assign rel_idx[3] = fl_if.releasedPhyMap3_i;

  fl_release_compact u_release_compact (
    .valid_i   (rel_valid),
    .idx_i     (rel_idx),
    .offset_o  (rel_offset),
    .wr_data_o (rel_data),
    .rel_cnt_o (rel_cnt)
  );

  // Allocation is gated by the stall and by recovery; oversized requests clamp to 4.
  always_comb begin
    req_cnt   = (fl_if.reqCount_i > 3'd4) ? 3'd4 : fl_if.reqCount_i;
    empty     = (free_cnt_q < fl_cnt_t'(4));
    alloc_cnt = (!empty && !fl_if.recoverFlag_i) ? req_cnt : 3'd0;
  end

  // Next-state: tail writes, pointer moves and count update.
  always_comb begin
    fl_d              = fl_q;
    wr_ptr            = '0;
    tail_ptr_d        = tail_ptr_q + fl_ptr_t'(rel_cnt);
    commit_head_ptr_d = commit_head_ptr_q + fl_ptr_t'(rel_cnt);
    head_ptr_d        = head_ptr_q + fl_ptr_t'(alloc_cnt);
    free_cnt_d        = free_cnt_q - fl_cnt_t'(alloc_cnt) + fl_cnt_t'(rel_cnt);
    for (int l = 0; l < NUM_LANES; l++) begin
      if (rel_valid[l]) begin
        wr_ptr       = tail_ptr_q + fl_ptr_t'(rel_offset[l]);
        fl_d[wr_ptr] = rel_data[l];
      end
    end
    if (fl_if.recoverFlag_i) begin
      // Everything past the committed head returns to the list; the
      // committed population is always the full depth.
      head_ptr_d = commit_head_ptr_q + fl_ptr_t'(rel_cnt);
      free_cnt_d = fl_cnt_t'(FL_DEPTH);
    end
    cnt_sum = {1'b0, free_cnt_q} + (FL_DEPTH_LOG+2)'(rel_cnt)
            - (FL_DEPTH_LOG+2)'(alloc_cnt);
  end

  // State registers; reset maps entry i to physical register SIZE_RMT+i.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        fl_q[i] <= phys_reg_t'(SIZE_RMT + i);
      end
      head_ptr_q        <= '0;
      commit_head_ptr_q <= '0;
      tail_ptr_q        <= '0;
      free_cnt_q        <= fl_cnt_t'(FL_DEPTH);
    end else begin
      fl_q              <= fl_d;
      head_ptr_q        <= head_ptr_d;
      commit_head_ptr_q <= commit_head_ptr_d;
      tail_ptr_q        <= tail_ptr_d;
      free_cnt_q        <= free_cnt_d;
    end
  end

  assign fl_if.freeReg0_o          = fl_q[head_ptr_q];
  assign fl_if.freeReg1_o          = fl_q[head_ptr_q + fl_ptr_t'(1)];
  assign fl_if.freeReg2_o          = fl_q[head_ptr_q + fl_ptr_t'(2)];
  assign fl_if.freeReg3_o          = fl_q[head_ptr_q + fl_ptr_t'(3)];
  assign fl_if.freeListEmpty_o     = empty;
  assign fl_if.freeCount_o         = free_cnt_q;
  assign fl_if.dbg_head_ptr        = head_ptr_q;
  assign fl_if.dbg_commit_head_ptr = commit_head_ptr_q;
  assign fl_if.dbg_tail_ptr        = tail_ptr_q;

  a_req_legal : assert property (@(posedge clk) disable iff (!reset)
    fl_if.reqCount_i <= 3'd4)
    else $error("reqCount_i above 4 treated as 4");

  a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
    fl_if.recoverFlag_i || (cnt_sum <= (FL_DEPTH_LOG+2)'(FL_DEPTH)))
    else $error("free count would exceed list depth");

endmodule

// File: tb/tb_spec_free_list.sv
// Directed bench for spec_free_list: hand-computed expectations per scenario.
module tb_spec_free_list;
  import spec_free_list_pkg::*;

  logic clk;
  logic reset;
  int   vec_cnt;
  int   err_cnt;

  spec_free_list_if fl_if ();

  spec_free_list dut (
    .clk   (clk),
    .reset (reset),
    .fl_if (fl_if)
  );

  logic [27:0] regs_obs;
  logic [27:0] e_regs;
  assign regs_obs = {fl_if.freeReg0_o, fl_if.freeReg1_o, fl_if.freeReg2_o, fl_if.freeReg3_o};

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t, required finish before it", $time);
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [2:0] req, input logic [3:0] v,
                       input logic [6:0] i0, input logic [6:0] i1,
                       input logic [6:0] i2, input logic [6:0] i3,
                       input logic rec);
    fl_if.reqCount_i        = req;
    fl_if.releasedValid0_i  = v[0];
    fl_if.releasedValid1_i  = v[1];
    fl_if.releasedValid2_i  = v[2];
    fl_if.releasedValid3_i  = v[3];
    fl_if.releasedPhyMap0_i = i0;
    fl_if.releasedPhyMap1_i = i1;
    fl_if.releasedPhyMap2_i = i2;
    fl_if.releasedPhyMap3_i = i3;
    fl_if.recoverFlag_i     = rec;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(3'd0, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    e_regs = {7'd32, 7'd33, 7'd34, 7'd35};
    vec_cnt++; if (regs_obs !== e_regs) begin err_cnt++; $display("FAIL reset_regs got %h exp %h", regs_obs, e_regs); end
    vec_cnt++; if (fl_if.freeListEmpty_o !== 1'b0) begin err_cnt++; $display("FAIL reset_empty got %b exp 0", fl_if.freeListEmpty_o); end
    vec_cnt++; if (fl_if.freeCount_o !== 7'd64) begin err_cnt++; $display("FAIL reset_count got %0d exp 64", fl_if.freeCount_o); end
    reset = 1'b1;
  endtask

  task automatic test_alloc();
    drive(3'd4, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0);
    cycle();
    e_regs = {7'd36, 7'd37, 7'd38, 7'd39};
    vec_cnt++; if (regs_obs !== e_regs) begin err_cnt++; $display("FAIL alloc4_regs got %h exp %h", regs_obs, e_regs); end
    vec_cnt++; if (fl_if.freeCount_o !== 7'd60) begin err_cnt++; $display("FAIL alloc4_count got %0d exp 60", fl_if.freeCount_o); end
    drive(3'd1, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0);
    cycle();
    e_regs = {7'd37, 7'd38, 7'd39, 7'd40};
    vec_cnt++; if (regs_obs !== e_regs) begin err_cnt++; $display("FAIL alloc1_regs got %h exp %h", regs_obs, e_regs); end
    vec_cnt++; if (fl_if.freeCount_o !== 7'd59) begin err_cnt++; $display("FAIL alloc1_count got %0d exp 59", fl_if.freeCount_o); end
    drive(3'd3, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0);
    cycle();
    e_regs = {7'd40, 7'd41, 7'd42, 7'd43};
    vec_cnt++; if (regs_obs !== e_regs) begin err_cnt++; $display("FAIL alloc3_regs got %h exp %h", regs_obs, e_regs); end
    vec_cnt++; if (fl_if.freeCount_o !== 7'd56) begin err_cnt++; $display("FAIL alloc3_count got %0d exp 56", fl_if.freeCount_o); end
    vec_cnt++; if (fl_if.dbg_head_ptr !== 6'd8) begin err_cnt++; $display("FAIL alloc3_head got %0d exp 8", fl_if.dbg_head_ptr); end
  endtask

  task automatic test_drain();
    drive(3'd4, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0);
    repeat (13) cycle();
    e_regs = {7'd92, 7'd93, 7'd94, 7'd95};
    vec_cnt++; if (regs_obs !== e_regs) begin err_cnt++; $display("FAIL drain4_regs got %h exp %h", regs_obs, e_regs); end
    vec_cnt++; if (fl_if.freeCount_o !== 7'd4) begin err_cnt++; $display("FAIL drain4_count got %0d exp 4", fl_if.freeCount_o); end
    vec_cnt++; if (fl_if.freeListEmpty_o !== 1'b0) begin err_cnt++; $display("FAIL drain4_empty got %b exp 0", fl_if.freeListEmpty_o); end
    cycle();
    vec_cnt++; if (fl_if.freeCount_o !== 7'd0) begin err_cnt++; $display("FAIL drain0_count got %0d exp 0", fl_if.freeCount_o); end
    vec_cnt++; if (fl_if.freeListEmpty_o !== 1'b1) begin err_cnt++; $display("FAIL drain0_empty got %b exp 1", fl_if.freeListEmpty_o); end
    vec_cnt++; if (fl_if.dbg_head_ptr !== 6'd0) begin err_cnt++; $display("FAIL drain0_head_wrap got %0d exp 0", fl_if.dbg_head_ptr); end
    cycle();
    vec_cnt++; if (fl_if.freeCount_o !== 7'd0) begin err_cnt++; $display("FAIL stall_count got %0d exp 0", fl_if.freeCount_o); end
    vec_cnt++; if (fl_if.dbg_head_ptr !== 6'd0) begin err_cnt++; $display("FAIL stall_head got %0d exp 0", fl_if.dbg_head_ptr); end
  endtask

  task automatic test_release_two();
    drive(3'd0, 4'b1010, 7'd77, 7'd5, 7'd88, 7'd9, 1'b0);
    cycle();
    e_regs = {7'd5, 7'd9, 7'd34, 7'd35};
    vec_cnt++; if (regs_obs !== e_regs) begin err_cnt++; $display("FAIL rel2_regs got %h exp %h", regs_obs, e_regs); end
    vec_cnt++; if (fl_if.freeCount_o !== 7'd2) begin err_cnt++; $display("FAIL rel2_count got %0d exp 2", fl_if.freeCount_o); end
    vec_cnt++; if (fl_if.freeListEmpty_o !== 1'b1) begin err_cnt++; $display("FAIL rel2_empty got %b exp 1", fl_if.freeListEmpty_o); end
    vec_cnt++; if (fl_if.dbg_tail_ptr !== 6'd2) begin err_cnt++; $display("FAIL rel2_tail got %0d exp 2", fl_if.dbg_tail_ptr); end
    vec_cnt++; if (fl_if.dbg_commit_head_ptr !== 6'd2) begin err_cnt++; $display("FAIL rel2_commit got %0d exp 2", fl_if.dbg_commit_head_ptr); end
  endtask

  task automatic test_back_to_back();
    drive(3'd0, 4'b1111, 7'd40, 7'd41, 7'd42, 7'd43, 1'b0);
    cycle();
    e_regs = {7'd5, 7'd9, 7'd40, 7'd41};
    vec_cnt++; if (regs_obs !== e_regs) begin err_cnt++; $display("FAIL rel4_regs got %h exp %h", regs_obs, e_regs); end
    vec_cnt++; if (fl_if.freeCount_o !== 7'd6) begin err_cnt++; $display("FAIL rel4_count got %0d exp 6", fl_if.freeCount_o); end
    vec_cnt++; if (fl_if.freeListEmpty_o !== 1'b0) begin err_cnt++; $display("FAIL rel4_empty got %b exp 0", fl_if.freeListEmpty_o); end
    drive(3'd4, 4'b1111, 7'd50, 7'd51, 7'd52, 7'd53, 1'b0);
    cycle();
    e_regs = {7'd42, 7'd43, 7'd50, 7'd51};
    vec_cnt++; if (regs_obs !== e_regs) begin err_cnt++; $display("FAIL b2b_regs got %h exp %h", regs_obs, e_regs); end
    vec_cnt++; if (fl_if.freeCount_o !== 7'd6) begin err_cnt++; $display("FAIL b2b_count got %0d exp 6", fl_if.freeCount_o); end
    vec_cnt++; if (fl_if.dbg_head_ptr !== 6'd4) begin err_cnt++; $display("FAIL b2b_head got %0d exp 4", fl_if.dbg_head_ptr); end
    vec_cnt++; if (fl_if.dbg_tail_ptr !== 6'd10) begin err_cnt++; $display("FAIL b2b_tail got %0d exp 10", fl_if.dbg_tail_ptr); end
  endtask

  task automatic test_recover();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    drive(3'd4, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0);
    repeat (3) cycle();
    vec_cnt++; if (fl_if.dbg_head_ptr !== 6'd12) begin err_cnt++; $display("FAIL prerec_head got %0d exp 12", fl_if.dbg_head_ptr); end
    vec_cnt++; if (fl_if.freeCount_o !== 7'd52) begin err_cnt++; $display("FAIL prerec_count got %0d exp 52", fl_if.freeCount_o); end
    drive(3'd4, 4'b0011, 7'd20, 7'd21, 7'd0, 7'd0, 1'b1);
    cycle();
    e_regs = {7'd34, 7'd35, 7'd36, 7'd37};
    vec_cnt++; if (regs_obs !== e_regs) begin err_cnt++; $display("FAIL rec_regs got %h exp %h", regs_obs, e_regs); end
    vec_cnt++; if (fl_if.dbg_head_ptr !== 6'd2) begin err_cnt++; $display("FAIL rec_head got %0d exp 2", fl_if.dbg_head_ptr); end
    vec_cnt++; if (fl_if.freeCount_o !== 7'd64) begin err_cnt++; $display("FAIL rec_count got %0d exp 64", fl_if.freeCount_o); end
    vec_cnt++; if (fl_if.dbg_commit_head_ptr !== 6'd2) begin err_cnt++; $display("FAIL rec_commit got %0d exp 2", fl_if.dbg_commit_head_ptr); end
    drive(3'd0, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1'b1);
    cycle();
    vec_cnt++; if (fl_if.dbg_head_ptr !== 6'd2) begin err_cnt++; $display("FAIL rec_hold_head got %0d exp 2", fl_if.dbg_head_ptr); end
    vec_cnt++; if (fl_if.freeCount_o !== 7'd64) begin err_cnt++; $display("FAIL rec_hold_count got %0d exp 64", fl_if.freeCount_o); end
    drive(3'd4, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0);
    repeat (15) cycle();
    e_regs = {7'd94, 7'd95, 7'd20, 7'd21};
    vec_cnt++; if (regs_obs !== e_regs) begin err_cnt++; $display("FAIL postrec_wrap_regs got %h exp %h", regs_obs, e_regs); end
    vec_cnt++; if (fl_if.freeCount_o !== 7'd4) begin err_cnt++; $display("FAIL postrec_count got %0d exp 4", fl_if.freeCount_o); end
  endtask

  task automatic test_async_reset();
    drive(3'd4, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0);
    cycle();
    #3;
    reset = 1'b0;
    #1;
    e_regs = {7'd32, 7'd33, 7'd34, 7'd35};
    vec_cnt++; if (regs_obs !== e_regs) begin err_cnt++; $display("FAIL areset_regs got %h exp %h", regs_obs, e_regs); end
    vec_cnt++; if (fl_if.freeListEmpty_o !== 1'b0) begin err_cnt++; $display("FAIL areset_empty got %b exp 0", fl_if.freeListEmpty_o); end
    vec_cnt++; if (fl_if.freeCount_o !== 7'd64) begin err_cnt++; $display("FAIL areset_count got %0d exp 64", fl_if.freeCount_o); end
    vec_cnt++; if (fl_if.dbg_head_ptr !== 6'd0) begin err_cnt++; $display("FAIL areset_head got %0d exp 0", fl_if.dbg_head_ptr); end
    drive(3'd0, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0);
    reset = 1'b1;
    cycle();
    vec_cnt++; if (fl_if.freeCount_o !== 7'd64) begin err_cnt++; $display("FAIL idle_count got %0d exp 64", fl_if.freeCount_o); end
  endtask

  // Scenario sequence and final report.
  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    reset   = 1'b0;
    test_reset();
    test_alloc();
    test_drain();
    test_release_two();
    test_back_to_back();
    test_recover();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
